hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Parametrised load-use / control hazard unit for the 5-stage RISC-V pipeline, ID stage.
//  Compares the ID_EX load destination against the IF_ID sources.
//  Adds stalls for multi-cycle load latency, a memory-busy freeze, and taken-branch flush.
//  Also keeps saturating stall and flush counters for performance analysis.
// PARAMETERS
//  REG_AW        5   register address width
//  LOAD_LATENCY  1   stall cycles per load-use hazard; legal range 1..15
//  ZERO_EXEMPT   1   1: rd==x0 never raises a hazard
//  CNT_W         16  width of the performance counters
// PORTS
//  clk                 in   1       rising-edge clock
//  reset               in   1       asynchronous, active-high
//  ID_EX_MemRead       in   1       instruction in EX is a load
//  ID_EX_Register_Rd   in   REG_AW  load destination register
//  IF_ID_Register_Rs1  in   REG_AW  ID source register 1
//  IF_ID_Register_Rs2  in   REG_AW  ID source register 2
//  IF_ID_Uses_Rs1      in   1       ID instruction reads rs1
//  IF_ID_Uses_Rs2      in   1       ID instruction reads rs2
//  branch_taken_i      in   1       EX resolved a taken branch or jump
//  mem_busy_i          in   1       data memory not ready; whole pipe must freeze
//  pc_stall_o          out  1       1 = hold PC
//  if_id_stall_o       out  1       1 = hold IF/ID register
//  id_ex_stall_o       out  1       1 = hold ID/EX register (mem_busy only)
//  bubble_sel_o        out  1       1 = mux zeros into ID/EX control signals
//  if_id_flush_o       out  1       1 = clear IF/ID register
//  id_ex_flush_o       out  1       1 = clear ID/EX register
//  stall_count_o       out  CNT_W   cycles with pc_stall_o=1, saturating
//  flush_count_o       out  CNT_W   cycles with if_id_flush_o=1, saturating
// BEHAVIOUR
//  - hit = ID_EX_MemRead & !(ZERO_EXEMPT & rd==0) & ((rd==rs1 & Uses_Rs1) | (rd==rs2 & Uses_Rs2)).
//  - State machine: IDLE, LOAD_STALL (down-counter cnt, 4 bits). FREEZE is a priority override, not a state.
//  - Priority each cycle: reset > mem_busy_i > branch_taken_i > load-use stall.
//  - mem_busy_i=1:
//    - pc/if_id/id_ex stall = 1; bubble and flush = 0.
//    - state and cnt hold; counters count the stall.
//  - branch_taken_i=1, mem_busy_i=0:
//    - if_id_flush_o = id_ex_flush_o = 1; all stall outputs 0.
//    - next state IDLE, cnt cleared; any pending load stall is aborted.
//  - IDLE & hit:
//    - Same cycle, combinationally: pc_stall_o = if_id_stall_o = bubble_sel_o = 1.
//    - If LOAD_LATENCY>1: next state LOAD_STALL, cnt = LOAD_LATENCY-1. Otherwise stay IDLE.
//  - LOAD_STALL:
//    - pc_stall_o = if_id_stall_o = bubble_sel_o = 1 regardless of hit.
//    - cnt decrements; when cnt==1, next state is IDLE.
//    - Total stall for one hazard = LOAD_LATENCY cycles, excluding mem_busy freezes.
//  - Back-to-back: a new hit in the IDLE cycle right after a stall starts a fresh stall; no merging.
//  - All outputs except the counters are combinational from inputs and state. No added latency.
//  - Counters are registered; they update on the edge after the counted cycle and saturate at all-ones.
//  - Reset (asynchronous): state IDLE, cnt 0, both counters 0.
//    - While reset=1, every output is forced to 0, including in mid-stall.
// TESTING
//  - LATENCY=1, MemRead=1, rd=5, rs1=5, Uses_Rs1=1 -> 1 cycle of pc/if_id stall and bubble; stall_count_o=1.
//  - LATENCY=3, same hazard -> stall high exactly 3 cycles, then IDLE; stall_count_o=3.
//  - rd=0, rs1=0, ZERO_EXEMPT=1 -> no stall. rd=7, rs2=7, Uses_Rs2=0 -> no stall.
//  - LATENCY=3, branch_taken_i in 2nd stall cycle -> that cycle both flushes=1, stall=0; next cycle idle; flush_count_o=1.
//  - LATENCY=2, mem_busy_i for 4 cycles mid-stall -> all three stalls held 4 cycles, cnt frozen; total pc_stall cycles=6.
//  - Reset pulse in LOAD_STALL -> outputs 0 immediately; after release IDLE with counters=0.
//  - CNT_W=2, 5 stall cycles -> stall_count_o saturates at 3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard unit: load-use stalls of configurable length, memory-busy freeze,
// taken-branch flush, and saturating stall/flush performance counters.
module hazard_stall_controller #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int ZERO_EXEMPT  = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_EX_MemRead,
    input  logic [REG_AW-1:0] ID_EX_Register_Rd,
    input  logic [REG_AW-1:0] IF_ID_Register_Rs1,
    input  logic [REG_AW-1:0] IF_ID_Register_Rs2,
    input  logic              IF_ID_Uses_Rs1,
    input  logic              IF_ID_Uses_Rs2,
    input  logic              branch_taken_i,
    input  logic              mem_busy_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              id_ex_stall_o,
    output logic              bubble_sel_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic [CNT_W-1:0]  stall_count_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    // state      | meaning
    // IDLE       | no load stall in progress; a hit starts one this cycle
    // LOAD_STALL | extra stall cycles of a multi-cycle load, cnt_q remaining
    typedef enum logic {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    localparam logic [3:0] RELOAD   = 4'(LOAD_LATENCY - 1);
    localparam bit         MULTI    = (LOAD_LATENCY > 1);
    localparam bit         ZX       = (ZERO_EXEMPT != 0);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               hit;
    logic               rd_exempt;

    always_comb begin
        rd_exempt = ZX && (ID_EX_Register_Rd == '0);
        hit = ID_EX_MemRead && !rd_exempt &&
              (((ID_EX_Register_Rd == IF_ID_Register_Rs1) && IF_ID_Uses_Rs1) ||
               ((ID_EX_Register_Rd == IF_ID_Register_Rs2) && IF_ID_Uses_Rs2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        id_ex_stall_o = 1'b0;
        bubble_sel_o  = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;

        // Outputs are forced low for the whole reset pulse, not just after the edge.
        if (reset) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (mem_busy_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = IDLE;
            cnt_d         = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        bubble_sel_o  = 1'b1;
                        if (MULTI) begin
                            state_d = LOAD_STALL;
                            cnt_d   = RELOAD;
                        end
                    end
                end
                LOAD_STALL: begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    bubble_sel_o  = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_id_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: four instances with different latency, counter width
// and x0 exemption share one stimulus stream and are checked against a remaining-cycles model.
module tb_hazard_stall_controller;

    localparam int N = 4;
    localparam int LAT_M [N] = '{1, 3, 2, 5};
    localparam int MAX_M [N] = '{65535, 65535, 65535, 3};
    localparam int ZX_M  [N] = '{1, 1, 0, 1};

    logic       clk;
    logic       reset;
    logic       mem_read;
    logic [4:0] rd, rs1, rs2;
    logic       use1, use2, br, busy;

    logic [5:0]  ctl [N];
    logic [15:0] sc  [N];
    logic [15:0] fc  [N];

    int checks = 0;
    int errors = 0;

    int rem  [N];
    int scnt [N];
    int fcnt [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 5;
        localparam int CW = (g == 3) ? 2 : 16;
        localparam int ZX = (g == 2) ? 0 : 1;
        logic [CW-1:0] s_w, f_w;
        logic pc_w, ifs_w, exs_w, bub_w, iff_w, exf_w;
        hazard_stall_controller #(
            .REG_AW(5), .LOAD_LATENCY(LT), .ZERO_EXEMPT(ZX), .CNT_W(CW)
        ) u_dut (
            .clk                (clk),
            .reset              (reset),
            .ID_EX_MemRead      (mem_read),
            .ID_EX_Register_Rd  (rd),
            .IF_ID_Register_Rs1 (rs1),
            .IF_ID_Register_Rs2 (rs2),
            .IF_ID_Uses_Rs1     (use1),
            .IF_ID_Uses_Rs2     (use2),
            .branch_taken_i     (br),
            .mem_busy_i         (busy),
            .pc_stall_o         (pc_w),
            .if_id_stall_o      (ifs_w),
            .id_ex_stall_o      (exs_w),
            .bubble_sel_o       (bub_w),
            .if_id_flush_o      (iff_w),
            .id_ex_flush_o      (exf_w),
            .stall_count_o      (s_w),
            .flush_count_o      (f_w)
        );
        assign ctl[g] = {pc_w, ifs_w, exs_w, bub_w, iff_w, exf_w};
        assign sc[g]  = 16'(s_w);
        assign fc[g]  = 16'(f_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, check all instances mid-cycle, then advance the model.
    task automatic step(input logic r, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic u1, input logic u2,
                        input logic b, input logic bz);
        logic [5:0] e;
        logic       h;
        reset = r; mem_read = mr; rd = d; rs1 = s1; rs2 = s2;
        use1 = u1; use2 = u2; br = b; busy = bz;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
            end
            h = mr && !((ZX_M[i] != 0) && (d == 5'd0)) &&
                (((d == s1) && u1) || ((d == s2) && u2));
            e = 6'b000000;
            if (r)              e = 6'b000000;
            else if (bz)        e = 6'b111000;
            else if (b)         e = 6'b000011;
            else if (rem[i] > 0) e = 6'b110100;
            else if (h)         e = 6'b110100;

            checks++;
            assert (ctl[i] === e) else begin
                errors++;
                $error("FAIL ctl[%0d] observed %b expected %b (pc,ifs,exs,bub,iff,exf)", i, ctl[i], e);
            end
            checks++;
            assert (sc[i] === 16'(scnt[i])) else begin
                errors++;
                $error("FAIL stall_count[%0d] observed %0d expected %0d", i, sc[i], scnt[i]);
            end
            checks++;
            assert (fc[i] === 16'(fcnt[i])) else begin
                errors++;
                $error("FAIL flush_count[%0d] observed %0d expected %0d", i, fc[i], fcnt[i]);
            end

            if (!r) begin
                if (e[5] && scnt[i] < MAX_M[i]) scnt[i]++;
                if (e[1] && fcnt[i] < MAX_M[i]) fcnt[i]++;
                if (!bz) begin
                    if (b)               rem[i] = 0;
                    else if (rem[i] > 0) rem[i] = rem[i] - 1;
                    else if (h)          rem[i] = LAT_M[i] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_use();
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        end
        reset = 1'b1; mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
        use1 = 1'b0; use2 = 1'b0; br = 1'b0; busy = 1'b0;

        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // single hazard: latencies 1/3/2/5, the 2-bit counter saturates at 3
        load_use();
        idle(6);

        // rd = x0 exempt (except the non-exempt instance), unused rs2 ignored
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(6);

        // branch in the second stall cycle aborts the stall
        load_use();
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // memory busy for 4 cycles mid-stall freezes the countdown
        load_use();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);

        // back-to-back hazards
        load_use();
        load_use();
        load_use();
        idle(6);

        // reset pulse in the middle of a stall
        load_use();
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
